// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 memory responder and its channel FSMs.
package lc3_mem_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned LAT_MAX = 15;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } chan_state_e;

endpackage

// File: rtl/lc3_mem_chan_fsm.sv
// One access channel: accepts a granted request, counts wait states, strobes
// the array access on the final wait edge and pulses done for one cycle.
module lc3_mem_chan_fsm
    import lc3_mem_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_i,
    input  logic        grant_i,
    input  word_t       addr_i,
    input  logic        rd_i,
    input  word_t       wdata_i,
    output chan_state_e state_o,
    output logic        access_c,
    output word_t       addr_o,
    output logic        rd_o,
    output word_t       wdata_o,
    output logic        done_o
);

    chan_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    word_t            addr_q;
    logic             rd_q;
    word_t            wdata_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            rd_q    <= 1'b1;
            wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i && grant_i) begin
                        addr_q  <= addr_i;
                        rd_q    <= rd_i;
                        wdata_q <= wdata_i;
                        cnt_q   <= CNT_W'(LAT - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // The array is touched on the edge that sees the counter at zero.
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= CNT_W'(cnt_q - 1'b1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign access_c = (state_q == WAIT) && (cnt_q == '0);
    assign state_o  = state_q;
    assign addr_o   = addr_q;
    assign rd_o     = rd_q;
    assign wdata_o  = wdata_q;
    assign done_o   = done_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// Unified single-port LC3 instruction/data memory with per-channel wait states,
// data-priority arbitration and a backdoor preload port.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned INSTR_LAT = 2,
    parameter int unsigned DATA_LAT  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       pc,
    input  logic              instrmem_rd,
    output logic [15:0]       Instr_dout,
    output logic              complete_instr,
    input  logic              data_req,
    input  logic [15:0]       Data_addr,
    input  logic              Data_rd,
    input  logic [15:0]       Data_dout,
    output logic [15:0]       Data_din,
    output logic              complete_data,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [15:0]       bd_wdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    word_t       mem_q [DEPTH];
    word_t       instr_dout_q;
    word_t       data_din_q;

    chan_state_e instr_state;
    chan_state_e data_state;
    logic        instr_access_c;
    logic        data_access_c;
    logic        instr_grant_c;
    logic        data_grant_c;
    word_t       instr_addr;
    word_t       data_addr;
    logic        data_rd;
    word_t       data_wdata;
    logic        instr_done;
    logic        data_done;
    logic        instr_unused_rd;
    word_t       instr_unused_wdata;
    logic        unused_addr_bits_c;

    // A channel in WAIT blocks the other; data wins a tie between idle channels.
    assign data_grant_c  = (instr_state != WAIT);
    assign instr_grant_c = (data_state != WAIT) && !(data_req && (data_state == IDLE));

    lc3_mem_chan_fsm #(.LAT(INSTR_LAT)) u_instr_fsm (
        .clock    (clock),
        .reset    (reset),
        .req_i    (instrmem_rd),
        .grant_i  (instr_grant_c),
        .addr_i   (pc),
        .rd_i     (1'b1),
        .wdata_i  ('0),
        .state_o  (instr_state),
        .access_c (instr_access_c),
        .addr_o   (instr_addr),
        .rd_o     (instr_unused_rd),
        .wdata_o  (instr_unused_wdata),
        .done_o   (instr_done)
    );

    lc3_mem_chan_fsm #(.LAT(DATA_LAT)) u_data_fsm (
        .clock    (clock),
        .reset    (reset),
        .req_i    (data_req),
        .grant_i  (data_grant_c),
        .addr_i   (Data_addr),
        .rd_i     (Data_rd),
        .wdata_i  (Data_dout),
        .state_o  (data_state),
        .access_c (data_access_c),
        .addr_o   (data_addr),
        .rd_o     (data_rd),
        .wdata_o  (data_wdata),
        .done_o   (data_done)
    );

    // Array is never reset; the later backdoor assignment wins a same-word race.
    always_ff @(posedge clock) begin
        if (reset && data_access_c && !data_rd) begin
            mem_q[data_addr[ADDR_W-1:0]] <= data_wdata;
        end
        if (bd_we) begin
            mem_q[bd_addr] <= bd_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            instr_dout_q <= '0;
            data_din_q   <= '0;
        end else begin
            if (instr_access_c) begin
                instr_dout_q <= mem_q[instr_addr[ADDR_W-1:0]];
            end
            if (data_access_c && data_rd) begin
                data_din_q <= mem_q[data_addr[ADDR_W-1:0]];
            end
        end
    end

    // Upper address bits wrap away by design.
    assign unused_addr_bits_c = ^{instr_addr[15:ADDR_W], data_addr[15:ADDR_W],
                                  instr_unused_rd, instr_unused_wdata};

    assign Instr_dout     = instr_dout_q;
    assign Data_din       = data_din_q;
    assign complete_instr = instr_done;
    assign complete_data  = data_done;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed self-checking bench for lc3_mem_responder (default parameters).
module tb_lc3_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        instrmem_rd;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic        data_req;
    logic [15:0] Data_addr;
    logic        Data_rd;
    logic [15:0] Data_dout;
    logic [15:0] Data_din;
    logic        complete_data;
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [15:0] bd_wdata;

    int npass = 0;
    int ntot  = 0;
    int n;
    int t_d;
    int t_i;
    bit ovl;

    lc3_mem_responder dut (
        .clock          (clock),
        .reset          (reset),
        .pc             (pc),
        .instrmem_rd    (instrmem_rd),
        .Instr_dout     (Instr_dout),
        .complete_instr (complete_instr),
        .data_req       (data_req),
        .Data_addr      (Data_addr),
        .Data_rd        (Data_rd),
        .Data_dout      (Data_dout),
        .Data_din       (Data_din),
        .complete_data  (complete_data),
        .bd_we          (bd_we),
        .bd_addr        (bd_addr),
        .bd_wdata       (bd_wdata)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_done(input bit is_data, input int max, output int cnt);
        bit found;
        found = 1'b0;
        cnt = 0;
        while (!found && cnt < max) begin
            step();
            cnt++;
            found = is_data ? complete_data : complete_instr;
        end
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [15:0] d);
        bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        step();
        bd_we = 1'b0;
    endtask

    task automatic do_fetch(input string tag, input logic [15:0] a);
        int c;
        pc = a; instrmem_rd = 1'b1;
        wait_done(1'b0, 20, c);
        instrmem_rd = 1'b0;
        check({tag, "_lat"}, 16'(c), 16'd3);
        step();
        check({tag, "_pulse_low"}, 16'(complete_instr), 16'h0);
    endtask

    task automatic do_data(input string tag, input logic rd, input logic [15:0] a,
                           input logic [15:0] wd);
        int c;
        data_req = 1'b1; Data_rd = rd; Data_addr = a; Data_dout = wd;
        wait_done(1'b1, 20, c);
        data_req = 1'b0;
        check({tag, "_lat"}, 16'(c), 16'd4);
        step();
        check({tag, "_pulse_low"}, 16'(complete_data), 16'h0);
    endtask

    initial begin
        reset = 1'b0; pc = 16'h0; instrmem_rd = 1'b1;
        data_req = 1'b0; Data_addr = 16'h0; Data_rd = 1'b1; Data_dout = 16'h0;
        bd_we = 1'b0; bd_addr = 8'h0; bd_wdata = 16'h0;

        // Reset held with a fetch pending
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_instr_dout", Instr_dout, 16'h0);
            check("rst_data_din", Data_din, 16'h0);
            check("rst_completes", {14'h0, complete_instr, complete_data}, 16'h0);
        end
        reset = 1'b1;
        wait_done(1'b0, 20, n);
        instrmem_rd = 1'b0;
        check("rel_fetch_lat", 16'(n), 16'd3);
        step();
        check("rel_fetch_pulse_low", 16'(complete_instr), 16'h0);

        // Preload and fetch
        bd_write(8'h10, 16'h1234);
        bd_write(8'h30, 16'h5555);
        bd_write(8'h50, 16'h1111);
        do_fetch("fetch_3010", 16'h3010);
        check("fetch_3010_data", Instr_dout, 16'h1234);

        // Write then read
        do_data("wr_20", 1'b0, 16'h0020, 16'hBEEF);
        check("wr_20_din_unchanged", Data_din, 16'h0);
        do_data("rd_20", 1'b1, 16'h0020, 16'h0);
        check("rd_20_data", Data_din, 16'hBEEF);

        // Collision: data wins, fetch follows on the data DONE cycle
        t_d = 0; t_i = 0; ovl = 1'b0;
        pc = 16'h3010; instrmem_rd = 1'b1;
        data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h0020;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (complete_data && complete_instr) ovl = 1'b1;
            if (complete_data && t_d == 0) begin t_d = c; data_req = 1'b0; end
            if (complete_instr && t_i == 0) begin t_i = c; instrmem_rd = 1'b0; end
        end
        check("coll_data_lat", 16'(t_d), 16'd4);
        check("coll_instr_lat", 16'(t_i), 16'd7);
        check("coll_overlap", 16'(ovl), 16'h0);
        check("coll_data_val", Data_din, 16'hBEEF);
        check("coll_instr_val", Instr_dout, 16'h1234);

        // Reset on the final wait edge of a write
        data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h0030; Data_dout = 16'h1111;
        step(); step(); step();
        reset = 1'b0; data_req = 1'b0;
        step();
        check("abort_no_pulse", 16'(complete_data), 16'h0);
        check("abort_din_cleared", Data_din, 16'h0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_quiet", 16'(complete_data), 16'h0);
        end
        do_data("rd_30", 1'b1, 16'h0030, 16'h0);
        check("rd_30_data", Data_din, 16'h5555);

        // Address wrap
        do_fetch("fetch_ff10", 16'hFF10);
        check("fetch_ff10_data", Instr_dout, 16'h1234);

        // Backdoor and core write to the same word on the same edge
        data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h0040; Data_dout = 16'hBBBB;
        step(); step(); step();
        bd_we = 1'b1; bd_addr = 8'h40; bd_wdata = 16'hAAAA;
        step();
        check("race_wr_done", 16'(complete_data), 16'h1);
        bd_we = 1'b0; data_req = 1'b0;
        step();
        do_data("rd_40", 1'b1, 16'h0140, 16'h0);
        check("rd_40_data", Data_din, 16'hAAAA);

        // Read completing on a backdoor write edge sees the old word
        data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h0050;
        step(); step(); step();
        bd_we = 1'b1; bd_addr = 8'h50; bd_wdata = 16'h2222;
        step();
        check("race_rd_done", 16'(complete_data), 16'h1);
        check("race_rd_old", Data_din, 16'h1111);
        bd_we = 1'b0; data_req = 1'b0;
        step();
        do_data("rd_50", 1'b1, 16'h0050, 16'h0);
        check("rd_50_new", Data_din, 16'h2222);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
